// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB write-back stage.
package mem_wb_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned FUNCT3_W  = 3;

    localparam logic [FUNCT3_W-1:0]  FUNCT3_LW = 3'b010;
    localparam logic [REG_IDX_W-1:0] ZERO_REG  = 5'd0;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT_LD = 2'd1,
        S_ERR     = 2'd2
    } wb_state_t;

    // Destination of an outstanding load, held while data memory responds
    typedef struct packed {
        logic                 reg_wr;
        logic [REG_IDX_W-1:0] idx;
    } wb_pend_t;

    function automatic logic is_word_load(input logic [FUNCT3_W-1:0] funct3);
        return funct3 == FUNCT3_LW;
    endfunction

    function automatic logic writes_reg(input logic reg_wr, input logic [REG_IDX_W-1:0] idx);
        return reg_wr && (idx != ZERO_REG);
    endfunction

    // Regfile index actually written; x0 and non-writing instructions map to 0
    function automatic logic [REG_IDX_W-1:0] wr_idx(input logic reg_wr,
                                                    input logic [REG_IDX_W-1:0] idx);
        return writes_reg(reg_wr, idx) ? idx : ZERO_REG;
    endfunction

endpackage

// File: rtl/mem_wb_stage_ld_timer.sv
// Load-response watchdog: counts cycles spent waiting and flags the last allowed one.
import mem_wb_stage_pkg::*;

module wb_ld_timer #(
    parameter int unsigned LOAD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOAD_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire_c = (count == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB register: retires EX/MEM results, merges multi-cycle load data, stalls upstream on a pending load.
// Optional retire counter port enabled by defining WB_RETIRE_CNT_EN.
import mem_wb_stage_pkg::*;

module mem_wb_stage #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LOAD_TIMEOUT = 64,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_mem_valid_inst,
    input  logic                 ex_mem_reg_wr,
    input  logic                 ex_mem_rd_mem,
    input  logic [REG_IDX_W-1:0] ex_mem_dest_reg_idx,
    input  logic [XLEN-1:0]      ex_mem_alu_result,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_data,
    output logic                 wb_stall,
    output logic                 mem_wb_valid_inst,
    output logic                 mem_wb_reg_wr,
    output logic [REG_IDX_W-1:0] mem_wb_dest_reg_idx,
    output logic [XLEN-1:0]      wb_reg_wr_data_out,
    output logic [REG_IDX_W-1:0] rd_mem_wb,
    output logic                 load_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [RETIRE_CNT_W-1:0] retire_cnt
`endif
);

    wb_state_t state, state_nxt;
    wb_pend_t  pend, pend_nxt;

    logic                 valid_nxt;
    logic                 reg_wr_nxt;
    logic [REG_IDX_W-1:0] dest_nxt;
    logic [XLEN-1:0]      data_nxt;
    logic [REG_IDX_W-1:0] rd_nxt;
    logic                 err_nxt;
    logic                 expire_c;

    wb_ld_timer #(
        .LOAD_TIMEOUT(LOAD_TIMEOUT)
    ) u_ld_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != S_WAIT_LD),
        .enable  (state == S_WAIT_LD),
        .expire_c(expire_c)
    );

    // Next state and next MEM/WB contents
    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        valid_nxt  = 1'b0;
        reg_wr_nxt = 1'b0;
        dest_nxt   = ZERO_REG;
        data_nxt   = '0;
        err_nxt    = load_err;

        case (state)
            S_RUN: begin
                if (ex_mem_valid_inst) begin
                    if (!ex_mem_rd_mem || mem_rsp_valid) begin
                        valid_nxt  = 1'b1;
                        reg_wr_nxt = writes_reg(ex_mem_reg_wr, ex_mem_dest_reg_idx);
                        dest_nxt   = wr_idx(ex_mem_reg_wr, ex_mem_dest_reg_idx);
                        data_nxt   = ex_mem_rd_mem ? mem_rsp_data : ex_mem_alu_result;
                    end else begin
                        pend_nxt.reg_wr = ex_mem_reg_wr;
                        pend_nxt.idx    = ex_mem_dest_reg_idx;
                        state_nxt       = S_WAIT_LD;
                    end
                end
            end
            S_WAIT_LD: begin
                if (mem_rsp_valid) begin
                    valid_nxt  = 1'b1;
                    reg_wr_nxt = writes_reg(pend.reg_wr, pend.idx);
                    dest_nxt   = wr_idx(pend.reg_wr, pend.idx);
                    data_nxt   = mem_rsp_data;
                    state_nxt  = S_RUN;
                end else if (expire_c) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                err_nxt = 1'b1;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase

        // Hazard index seen by ID in the cycle after this edge
        if (state_nxt == S_WAIT_LD) begin
            rd_nxt = pend_nxt.idx;
        end else if (valid_nxt && reg_wr_nxt) begin
            rd_nxt = dest_nxt;
        end else begin
            rd_nxt = ZERO_REG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_RUN;
            pend                <= '0;
            wb_stall            <= 1'b0;
            mem_wb_valid_inst   <= 1'b0;
            mem_wb_reg_wr       <= 1'b0;
            mem_wb_dest_reg_idx <= ZERO_REG;
            wb_reg_wr_data_out  <= '0;
            rd_mem_wb           <= ZERO_REG;
            load_err            <= 1'b0;
        end else begin
            state               <= state_nxt;
            pend                <= pend_nxt;
            wb_stall            <= (state_nxt != S_RUN);
            mem_wb_valid_inst   <= valid_nxt;
            mem_wb_reg_wr       <= reg_wr_nxt;
            mem_wb_dest_reg_idx <= dest_nxt;
            wb_reg_wr_data_out  <= data_nxt;
            rd_mem_wb           <= rd_nxt;
            load_err            <= err_nxt;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (valid_nxt) begin
            retire_cnt <= retire_cnt + RETIRE_CNT_W'(1);
        end
    end
`else
    logic unused_retire_cnt_w;
    assign unused_retire_cnt_w = 1'(RETIRE_CNT_W & 32'd1);
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver feeds a reference model, monitor checks every cycle.
module tb_mem_wb_stage;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned LOAD_TIMEOUT = 64;
    localparam int unsigned RCW          = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ex_mem_valid_inst = 1'b0;
    logic            ex_mem_reg_wr = 1'b0;
    logic            ex_mem_rd_mem = 1'b0;
    logic [4:0]      ex_mem_dest_reg_idx = 5'd0;
    logic [XLEN-1:0] ex_mem_alu_result = '0;
    logic            mem_rsp_valid = 1'b0;
    logic [XLEN-1:0] mem_rsp_data = '0;
    logic            wb_stall;
    logic            mem_wb_valid_inst;
    logic            mem_wb_reg_wr;
    logic [4:0]      mem_wb_dest_reg_idx;
    logic [XLEN-1:0] wb_reg_wr_data_out;
    logic [4:0]      rd_mem_wb;
    logic            load_err;
`ifdef WB_RETIRE_CNT_EN
    logic [RCW-1:0]  retire_cnt;
`endif

    mem_wb_stage #(
        .XLEN(XLEN), .LOAD_TIMEOUT(LOAD_TIMEOUT), .RETIRE_CNT_W(RCW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_mem_valid_inst  (ex_mem_valid_inst),
        .ex_mem_reg_wr      (ex_mem_reg_wr),
        .ex_mem_rd_mem      (ex_mem_rd_mem),
        .ex_mem_dest_reg_idx(ex_mem_dest_reg_idx),
        .ex_mem_alu_result  (ex_mem_alu_result),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_data       (mem_rsp_data),
        .wb_stall           (wb_stall),
        .mem_wb_valid_inst  (mem_wb_valid_inst),
        .mem_wb_reg_wr      (mem_wb_reg_wr),
        .mem_wb_dest_reg_idx(mem_wb_dest_reg_idx),
        .wb_reg_wr_data_out (wb_reg_wr_data_out),
        .rd_mem_wb          (rd_mem_wb),
        .load_err           (load_err)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt         (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] rcnt;
        logic [XLEN-1:0] data;
        logic [4:0]      dest;
        logic [4:0]      rd;
        logic            valid;
        logic            reg_wr;
        logic            stall;
        logic            err;
        string           tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: 0 = running, 1 = awaiting load data, 2 = timed out
    int          m_mode = 0;
    int          m_waited = 0;
    logic [4:0]  m_prd = 5'd0;
    logic        m_pwr = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_rcnt = 32'd0;

    // One clock edge: apply inputs, predict the MEM/WB contents that follow it
    task automatic step(input string tag, input logic r, input logic v, input logic w,
                        input logic ld, input logic [4:0] d, input logic [31:0] alu,
                        input logic rv, input logic [31:0] rdata);
        exp_t e;
        @(negedge clk);
        rst = r; ex_mem_valid_inst = v; ex_mem_reg_wr = w; ex_mem_rd_mem = ld;
        ex_mem_dest_reg_idx = d; ex_mem_alu_result = alu;
        mem_rsp_valid = rv; mem_rsp_data = rdata;
        e.valid = 1'b0; e.reg_wr = 1'b0; e.dest = 5'd0; e.data = 32'd0; e.tag = tag;
        if (r) begin
            m_mode = 0; m_waited = 0; m_prd = 5'd0; m_pwr = 1'b0; m_err = 1'b0; m_rcnt = 32'd0;
        end else if (m_mode == 0) begin
            if (v && (!ld || rv)) begin
                e.valid = 1'b1;
                e.reg_wr = w && (d != 5'd0);
                e.dest = e.reg_wr ? d : 5'd0;
                e.data = ld ? rdata : alu;
            end else if (v) begin
                m_mode = 1; m_waited = 0; m_prd = d; m_pwr = w;
            end
        end else if (m_mode == 1) begin
            if (rv) begin
                e.valid = 1'b1;
                e.reg_wr = m_pwr && (m_prd != 5'd0);
                e.dest = e.reg_wr ? m_prd : 5'd0;
                e.data = rdata;
                m_mode = 0;
            end else if (m_waited == int'(LOAD_TIMEOUT) - 1) begin
                m_mode = 2; m_err = 1'b1;
            end else begin
                m_waited++;
            end
        end
        if (e.valid) m_rcnt = m_rcnt + 32'd1;
        e.stall = (m_mode != 0);
        e.rd = (m_mode == 1) ? m_prd : ((e.valid && e.reg_wr) ? e.dest : 5'd0);
        e.err = m_err;
        e.rcnt = m_rcnt;
        sb.push_back(e);
    endtask

    // Monitor: compares the DUT against the oldest prediction after every edge
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                ok = (mem_wb_valid_inst === e.valid) && (mem_wb_reg_wr === e.reg_wr) &&
                     (mem_wb_dest_reg_idx === e.dest) && (wb_reg_wr_data_out === e.data) &&
                     (wb_stall === e.stall) && (rd_mem_wb === e.rd) && (load_err === e.err);
`ifdef WB_RETIRE_CNT_EN
                ok = ok && (retire_cnt === e.rcnt);
`endif
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL %s t=%0t got v=%b w=%b d=%0d data=%h st=%b rd=%0d err=%b want v=%b w=%b d=%0d data=%h st=%b rd=%0d err=%b rcnt=%0d",
                             e.tag, $time, mem_wb_valid_inst, mem_wb_reg_wr, mem_wb_dest_reg_idx,
                             wb_reg_wr_data_out, wb_stall, rd_mem_wb, load_err,
                             e.valid, e.reg_wr, e.dest, e.data, e.stall, e.rd, e.err, e.rcnt);
                end
            end
        end
    end

    initial begin
        logic        hv, hw, hl, r, rv;
        logic [4:0]  hd;
        logic [31:0] ha;

        step("reset0", 1, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
        step("reset1", 1, 0, 0, 0, 5'd0, 32'd0, 1, 32'h5555);

        step("add_x5", 0, 1, 1, 0, 5'd5, 32'h1234, 0, 32'd0);
        step("lw_x7_fast", 0, 1, 1, 1, 5'd7, 32'h0, 1, 32'hCAFE0001);

        step("lw_x7_slow", 0, 1, 1, 1, 5'd7, 32'h0, 0, 32'd0);
        step("wait1", 0, 1, 1, 0, 5'd9, 32'h99, 0, 32'd0);
        step("wait2", 0, 1, 1, 0, 5'd9, 32'h99, 0, 32'd0);
        step("lw_rsp", 0, 1, 1, 0, 5'd9, 32'h99, 1, 32'hDEAD);
        step("held_add", 0, 1, 1, 0, 5'd9, 32'h99, 0, 32'd0);

        step("addi_x0", 0, 1, 1, 0, 5'd0, 32'h77, 0, 32'd0);
        step("store", 0, 1, 0, 0, 5'd12, 32'h400, 0, 32'd0);
        step("stray_rsp", 0, 0, 0, 0, 5'd3, 32'h1, 1, 32'hBAD);
        step("bubble", 0, 0, 1, 0, 5'd6, 32'h2, 0, 32'd0);

        step("lw_x3_to", 0, 1, 1, 1, 5'd3, 32'h0, 0, 32'd0);
        for (int i = 0; i < int'(LOAD_TIMEOUT) + 4; i++)
            step("timeout", 0, 1, 1, 0, 5'd4, 32'h44, 0, 32'd0);
        step("err_rsp", 0, 1, 1, 0, 5'd4, 32'h44, 1, 32'hF00D);
        step("err_hold", 0, 1, 1, 0, 5'd4, 32'h44, 0, 32'd0);

        step("rst_err", 1, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
        step("lw_x4", 0, 1, 1, 1, 5'd4, 32'h0, 0, 32'd0);
        step("wait_x4", 0, 1, 1, 0, 5'd8, 32'h8, 0, 32'd0);
        step("rst_wait", 1, 1, 1, 0, 5'd8, 32'h8, 0, 32'd0);
        step("late_rsp", 0, 0, 0, 0, 5'd0, 32'd0, 1, 32'h1111);
        step("after_rst", 0, 1, 1, 0, 5'd8, 32'h8, 0, 32'd0);

        hv = 0; hw = 0; hl = 0; hd = 5'd0; ha = 32'd0;
        for (int i = 0; i < 2000; i++) begin
            if (m_mode == 0) begin
                hv = ($urandom_range(0, 9) < 8);
                hw = ($urandom_range(0, 9) < 8);
                hl = ($urandom_range(0, 9) < 3);
                hd = 5'($urandom_range(0, 31));
                ha = $urandom;
            end
            if (m_mode == 1)      rv = ($urandom_range(0, 9) < 3);
            else if (hv && hl)    rv = ($urandom_range(0, 9) < 4);
            else                  rv = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 199) == 0);
            step("random", r, hv, hw, hl, hd, ha, rv, $urandom);
        end
        step("drain", 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);

        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
